aq_f_spsram_init: RTL and testbench
===================================

AQ_F_SPSRAM_INIT -- requirements
Module: aq_f_spsram_init

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, meaning address bits; depth DEPTH = 2^ADDR_WIDTH entries.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 59, meaning word width in bits.
REQ-003 The block SHALL have parameter INIT_DATA, default {DATA_WIDTH{1'b0}}, meaning the value written to every entry by the init sweep.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port A, input, ADDR_WIDTH bits: access address.
REQ-008 The block SHALL have port CEN, input, 1 bit: chip enable, active low.
REQ-009 The block SHALL have port GWEN, input, 1 bit: global write enable, 1 = write, 0 = read.
REQ-010 The block SHALL have port WEN, input, DATA_WIDTH bits: per-bit write enable, 1 = bit written.
REQ-011 The block SHALL have port D, input, DATA_WIDTH bits: write data.
REQ-012 The block SHALL have port INIT_REQ, input, 1 bit: single-cycle request to re-run the init sweep.
REQ-013 The block SHALL have port Q, output, DATA_WIDTH bits: read data.
REQ-014 The block SHALL have port INIT_BUSY, output, 1 bit: high while the init sweep is in progress.

Function
REQ-015 The block SHALL contain a behavioural array of DEPTH x DATA_WIDTH storage bits.
REQ-016 The block SHALL run an FSM with two states: SWEEP and IDLE; INIT_BUSY SHALL be 1 exactly when the state is SWEEP.
REQ-017 In SWEEP, the block SHALL write INIT_DATA to address cnt each cycle, with cnt running 0..DEPTH-1 and incrementing by 1 per cycle.
REQ-018 When cnt = DEPTH-1, the block SHALL write that final entry and go to IDLE on the next edge, leaving cnt at 0; there SHALL be no wrap-around rewrite.
REQ-019 A full sweep SHALL therefore take exactly DEPTH cycles of INIT_BUSY=1.
REQ-020 While in SWEEP, CEN, GWEN, WEN, D and A SHALL be ignored, and INIT_REQ SHALL be ignored (no restart, no queueing).
REQ-021 In IDLE, INIT_REQ=1 SHALL move the FSM to SWEEP with cnt=0 on the next edge. If CEN=0 is also asserted in that same cycle, the user access SHALL still complete in that cycle.
REQ-022 In IDLE with CEN=0 and GWEN=1, each bit i with WEN[i]=1 SHALL take D[i] at address A, bits with WEN[i]=0 SHALL keep their value, and Q SHALL be unchanged.
REQ-023 In IDLE with CEN=0 and GWEN=0, the block SHALL return mem[A] on Q one edge after the request (latency 1, base build).
REQ-024 With CEN=1, or in SWEEP, Q SHALL hold its previous value.
REQ-025 A read issued in the first IDLE cycle after a sweep SHALL return INIT_DATA, unless that entry has been written since.

Reset
REQ-026 RST=1 SHALL set the state to SWEEP, cnt to 0 and Q to 0; INIT_BUSY SHALL read 1 in the cycle after reset is sampled.
REQ-027 Reset asserted mid-sweep SHALL restart the sweep from address 0.
REQ-028 Reset SHALL have priority over INIT_REQ and over any user access in the same cycle.
REQ-029 Array contents SHALL NOT be reset directly; they are cleared only by the sweep.

Configuration
REQ-030 With macro AQ_SPSRAM_OUT_REG_EN defined, the block SHALL add an output pipeline register, making read latency 2 cycles. The register SHALL reset to 0 and SHALL load only when the first stage holds new read data.
REQ-031 Without AQ_SPSRAM_OUT_REG_EN, read latency SHALL be 1 cycle with no extra register.

Verification
REQ-032 Reset test: DEPTH=256, release RST -> INIT_BUSY=1 for exactly 256 cycles, then 0; a read of address 0xFF then returns 0.
REQ-033 Byte-mask write test: write D=all-ones, WEN=0xFF (low 8 bits), A=0x10; then read A=0x10 -> Q=0x0FF one cycle later (two cycles later with AQ_SPSRAM_OUT_REG_EN).
REQ-034 Mid-sweep reset test: pulse RST at sweep cycle 100 -> sweep restarts at cnt 0, INIT_BUSY stays high for a further 256 cycles.
REQ-035 Ignored-access test: during SWEEP, issue a write of 0x5A to A=3 and pulse INIT_REQ -> after the sweep, A=3 reads 0 and no second sweep occurs.
REQ-036 Simultaneous request test: in IDLE, write 0x1 to A=7 in the same cycle as INIT_REQ=1 -> INIT_BUSY=1 next cycle; after the sweep, A=7 reads 0.

Source files
------------

// File: rtl/aq_f_spsram_init.sv
// aq_f_spsram_init: single-port behavioural SRAM with a self-clearing init sweep.
// After reset (or an INIT_REQ pulse while idle) every entry is written with
// INIT_DATA, one address per cycle, while INIT_BUSY is high.
// Optional build macro: AQ_SPSRAM_OUT_REG_EN adds an output pipeline register
// (read latency 2 instead of 1).
module aq_f_spsram_init #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 59,
  parameter logic [DATA_WIDTH-1:0] INIT_DATA  = {DATA_WIDTH{1'b0}}
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  INIT_REQ,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  INIT_BUSY,
  output logic                  state_dbg
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Encoding is visible on state_dbg: 0 = IDLE, 1 = SWEEP.
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0]   q1;

  // Access protocol: a user access is accepted on a rising edge when CEN=0,
  // the FSM is IDLE and RST=0. There is no backpressure. GWEN=1 writes the
  // WEN-selected bits of D to mem[A]; GWEN=0 reads mem[A], which appears on
  // Q after the read latency and then holds until the next accepted read.
  logic user_acc;
  logic user_wr;
  logic user_rd;

  assign user_acc = (state == IDLE) && !CEN && !RST;
  assign user_wr  = user_acc && GWEN;
  assign user_rd  = user_acc && !GWEN;

  assign state_dbg = state;

  // Init FSM: sweep 0..DEPTH-1 once, then idle until re-requested.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= SWEEP;
      cnt       <= '0;
      INIT_BUSY <= 1'b1;
    end else begin
      case (state)
        SWEEP: begin
          if (&cnt) begin
            // Final entry written this edge; no wrap-around rewrite.
            state     <= IDLE;
            cnt       <= '0;
            INIT_BUSY <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_WIDTH'(1);
          end
        end
        IDLE: begin
          if (INIT_REQ) begin
            state     <= SWEEP;
            cnt       <= '0;
            INIT_BUSY <= 1'b1;
          end
        end
        default: begin
          state     <= SWEEP;
          cnt       <= '0;
          INIT_BUSY <= 1'b1;
        end
      endcase
    end
  end

  // Storage array: sweep writes take precedence; user writes honour the bit mask.
  // The array itself is never reset, only cleared by the sweep.
  always_ff @(posedge CLK) begin
    if (!RST && (state == SWEEP)) begin
      mem[cnt] <= INIT_DATA;
    end else if (user_wr) begin
      mem[A] <= (mem[A] & ~WEN) | (D & WEN);
    end
  end

  // First read stage: capture mem[A] on an accepted read, otherwise hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q1 <= '0;
    end else if (user_rd) begin
      q1 <= mem[A];
    end
  end

`ifdef AQ_SPSRAM_OUT_REG_EN
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] q2;

  // Output register: loads only when the first stage has just taken new read data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_vld <= 1'b0;
      q2     <= '0;
    end else begin
      rd_vld <= user_rd;
      if (rd_vld) begin
        q2 <= q1;
      end
    end
  end

  assign Q = q2;
`else
  assign Q = q1;
`endif

endmodule

// File: tb/tb_aq_f_spsram_init.sv
// tb_aq_f_spsram_init: vector table + directed sequences for aq_f_spsram_init,
// with read results checked through an expected-value queue.
module tb_aq_f_spsram_init;

  localparam int AW    = 8;
  localparam int DW    = 59;
  localparam int DEPTH = 1 << AW;
`ifdef AQ_SPSRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] a;
  logic          cen;
  logic          gwen;
  logic [DW-1:0] wen;
  logic [DW-1:0] d;
  logic          init_req;
  logic [DW-1:0] q;
  logic          init_busy;
  logic          state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  aq_f_spsram_init #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .A        (a),
    .CEN      (cen),
    .GWEN     (gwen),
    .WEN      (wen),
    .D        (d),
    .INIT_REQ (init_req),
    .Q        (q),
    .INIT_BUSY(init_busy),
    .state_dbg(state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q[$];
  int            due_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      void'(due_q.pop_front());
      check("read_q", 64'(q), 64'(e));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    cen = 1'b1; gwen = 1'b0; wen = '0; d = '0; a = '0; init_req = 1'b0;
  endtask

  task automatic do_nop();
    @(negedge clk);
    set_idle();
  endtask

  task automatic do_write(input logic [AW-1:0] wa, input logic [DW-1:0] wm, input logic [DW-1:0] wd);
    @(negedge clk);
    set_idle();
    cen = 1'b0; gwen = 1'b1; a = wa; wen = wm; d = wd;
    model[wa] = (model[wa] & ~wm) | (wd & wm);
  endtask

  task automatic do_read(input logic [AW-1:0] ra, input logic [DW-1:0] e);
    @(negedge clk);
    set_idle();
    cen = 1'b0; gwen = 1'b0; a = ra;
    exp_q.push_back(e);
    due_q.push_back(cyc + LAT);
  endtask

  // Returns at a negedge with RST just released (sweep about to start).
  task automatic do_reset();
    @(negedge clk);
    set_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(init_busy), 64'd1);
    check("reset_q", 64'(q), 64'd0);
    rst = 1'b0;
  endtask

  // Counts negedges with INIT_BUSY high starting at the current one.
  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      if (!init_busy) break;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    due_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] mask;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int n;
    int seen;
    logic [63:0] r1;
    logic [63:0] r2;

    tbl[0]  = '{1'b1, 8'h10, 59'hFF,            {DW{1'b1}},       59'h0};
    tbl[1]  = '{1'b0, 8'h10, 59'h0,             59'h0,            59'hFF};
    tbl[2]  = '{1'b1, 8'h20, {DW{1'b1}},        59'h123456789,    59'h0};
    tbl[3]  = '{1'b0, 8'h20, 59'h0,             59'h0,            59'h123456789};
    tbl[4]  = '{1'b1, 8'h20, 59'hF0,            59'h0,            59'h0};
    tbl[5]  = '{1'b0, 8'h20, 59'h0,             59'h0,            59'h123456709};
    tbl[6]  = '{1'b1, 8'hFF, {DW{1'b1}},        {DW{1'b1}},       59'h0};
    tbl[7]  = '{1'b0, 8'hFF, 59'h0,             59'h0,            {DW{1'b1}}};
    tbl[8]  = '{1'b0, 8'h00, 59'h0,             59'h0,            59'h0};
    tbl[9]  = '{1'b1, 8'h00, 59'hFF00,          59'hAAAA,         59'h0};
    tbl[10] = '{1'b0, 8'h00, 59'h0,             59'h0,            59'hAA00};
    tbl[11] = '{1'b0, 8'h10, 59'h0,             59'h0,            59'hFF};

    set_idle();
    rst = 1'b1;
    clear_model();

    // Power-up reset and first full sweep.
    do_reset();
    count_busy(n);
    check("sweep_len_256", 64'(n), 64'd256);
    do_read(8'hFF, '0);
    do_nop();
    drain();

    // Table-driven writes and reads.
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].mask, tbl[i].data);
      else           do_read(tbl[i].addr, tbl[i].exp);
    end
    do_nop();
    drain();

    // Q holds with CEN=1 and across a write.
    @(negedge clk);
    set_idle();
    a = 8'h20;
    repeat (3) @(negedge clk);
    check("hold_cen1", 64'(q), 64'hFF);
    do_write(8'h30, {DW{1'b1}}, 59'h777);
    do_nop();
    do_nop();
    do_nop();
    check("hold_after_write", 64'(q), 64'hFF);

    // Read in the same cycle as INIT_REQ completes, then sweep runs.
    @(negedge clk);
    set_idle();
    cen = 1'b0; gwen = 1'b0; a = 8'h10; init_req = 1'b1;
    exp_q.push_back(model[8'h10]);
    due_q.push_back(cyc + LAT);
    @(negedge clk);
    set_idle();
    check("initreq_busy_next", 64'(init_busy), 64'd1);
    count_busy(n);
    check("initreq_sweep_len", 64'(n), 64'd256);
    clear_model();
    drain();
    do_read(8'h10, model[8'h10]);
    do_read(8'h30, model[8'h30]);
    do_nop();
    drain();

    // Write in the same cycle as INIT_REQ: sweep clears it afterwards.
    @(negedge clk);
    set_idle();
    cen = 1'b0; gwen = 1'b1; a = 8'h07; wen = {DW{1'b1}}; d = 59'h1; init_req = 1'b1;
    @(negedge clk);
    set_idle();
    check("simul_busy_next", 64'(init_busy), 64'd1);
    count_busy(n);
    check("simul_sweep_len", 64'(n), 64'd256);
    clear_model();
    do_read(8'h07, '0);
    do_nop();
    drain();

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      logic [AW-1:0] ra;
      ra = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        r1 = {$urandom, $urandom};
        r2 = {$urandom, $urandom};
        do_write(ra, r1[DW-1:0], r2[DW-1:0]);
      end else begin
        do_read(ra, model[ra]);
      end
    end
    do_nop();
    drain();

    // Accesses and INIT_REQ during a sweep are ignored.
    do_reset();
    repeat (10) @(negedge clk);
    cen = 1'b0; gwen = 1'b1; a = 8'h03; wen = {DW{1'b1}}; d = 59'h5A; init_req = 1'b1;
    @(negedge clk);
    set_idle();
    count_busy(n);
    check("ignored_sweep_rest", 64'(n), 64'd245);
    clear_model();
    do_read(8'h03, '0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      set_idle();
      if (init_busy) seen++;
    end
    check("no_second_sweep", 64'(seen), 64'd0);
    drain();

    // Reset in the middle of a sweep restarts it from address 0.
    do_reset();
    repeat (100) @(negedge clk);
    check("mid_busy_at_100", 64'(init_busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_busy(n);
    check("mid_restart_len", 64'(n), 64'd256);
    do_read(8'h10, '0);
    do_nop();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
